// File: rtl/cpu_ctrl_pkg.sv
// Shared types for the CPU execution controller: sequencer state encoding
// as shown on the 7-segment display.
package cpu_ctrl_pkg;

  localparam int RUN_STATE_W = 3;

  typedef enum logic [RUN_STATE_W-1:0] {
    ST_HALT   = 3'd0,
    ST_RUN    = 3'd1,
    ST_STEP   = 3'd2,
    ST_BRK    = 3'd3,
    ST_RESUME = 3'd4
  } run_state_t;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: two-flop synchronizer, stability counter tracking
// the accepted level, and a one-cycle pulse on each accepted rising level.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

  logic [1:0]       sync_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             level_reg;
  logic             press_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg  <= '0;
      cnt_reg   <= '0;
      level_reg <= 1'b0;
      press_reg <= 1'b0;
    end else begin
      sync_reg  <= {sync_reg[0], btn_raw};
      press_reg <= 1'b0;
      if (sync_reg[1] == level_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        // The DEBOUNCE_CYCLES-th consecutive disagreeing sample flips the level
        level_reg <= ~level_reg;
        press_reg <= ~level_reg;
        cnt_reg   <= '0;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign level = level_reg;
  assign press = press_reg;

endmodule

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: debounced run/step/halt sequencer producing the CPU clock enable.
// Define CPU_RUN_CTRL_BREAKPOINT_EN to add the PC breakpoint with BRK/RESUME states.
module cpu_run_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   btn_run,
  input  logic                   btn_step,
  input  logic                   btn_halt,
  input  logic [31:0]            pc,
  input  logic [31:0]            bp_addr,
  input  logic                   bp_valid,
  output logic                   cpu_en,
  output logic [RUN_STATE_W-1:0] state,
  output logic [31:0]            cycle_cnt,
  output logic                   bp_hit
);

  localparam int BTN_RUN  = 0;
  localparam int BTN_STEP = 1;
  localparam int BTN_HALT = 2;

  logic [2:0] btn_vec;
  logic [2:0] level_vec;
  logic [2:0] press_vec;

  assign btn_vec = {btn_halt, btn_step, btn_run};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : gen_btn
      btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_db (
        .clk    (clk),
        .rst    (rst),
        .btn_raw(btn_vec[gi]),
        .level  (level_vec[gi]),
        .press  (press_vec[gi])
      );
    end
  endgenerate

  run_state_t  state_reg, state_next;
  logic [31:0] cycle_cnt_reg;
  logic        bp_match;

`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
  // Remembers whether RESUME was entered by run (continue) or step (stop after)
  logic resume_run_reg, resume_run_next;

  assign bp_match = bp_valid && (pc == bp_addr);
`else
  assign bp_match = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    cpu_en     = 1'b0;
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
    resume_run_next = resume_run_reg;
`endif
    case (state_reg)
      ST_RUN:    cpu_en = !bp_match;
      ST_STEP:   cpu_en = 1'b1;
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
      ST_RESUME: cpu_en = 1'b1;
`endif
      default:   cpu_en = 1'b0;
    endcase

    if (press_vec[BTN_HALT]) begin
      state_next = ST_HALT;
    end else begin
      case (state_reg)
        ST_HALT: begin
          if (press_vec[BTN_STEP])     state_next = ST_STEP;
          else if (press_vec[BTN_RUN]) state_next = ST_RUN;
        end
        ST_STEP: state_next = ST_HALT;
        ST_RUN: begin
          if (bp_match) state_next = ST_BRK;
        end
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
        ST_BRK: begin
          if (press_vec[BTN_STEP] || press_vec[BTN_RUN]) begin
            state_next      = ST_RESUME;
            resume_run_next = !press_vec[BTN_STEP];
          end
        end
        ST_RESUME: state_next = resume_run_reg ? ST_RUN : ST_HALT;
`endif
        default: state_next = ST_HALT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_HALT;
      cycle_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (cpu_en) cycle_cnt_reg <= cycle_cnt_reg + 32'd1;
    end
  end

`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
  always_ff @(posedge clk) begin
    if (rst) resume_run_reg <= 1'b0;
    else     resume_run_reg <= resume_run_next;
  end

  assign bp_hit = (state_reg == ST_BRK);
`else
  assign bp_hit = 1'b0;
`endif

  assign state     = state_reg;
  assign cycle_cnt = cycle_cnt_reg;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl with DEBOUNCE_CYCLES=4: a cycle model
// checked every cycle plus directed scenarios with hand-computed values.
module tb_cpu_run_ctrl;

  localparam int D = 4;
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
  localparam bit BP_EN = 1'b1;
`else
  localparam bit BP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        btn_run = 1'b0, btn_step = 1'b0, btn_halt = 1'b0;
  logic [31:0] pc;
  logic [31:0] bp_addr = 32'h0;
  logic        bp_valid = 1'b0;
  logic        cpu_en;
  logic [2:0]  state;
  logic [31:0] cycle_cnt;
  logic        bp_hit;

  int checks = 0;
  int errors = 0;

  cpu_run_ctrl #(.DEBOUNCE_CYCLES(D)) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_run  (btn_run),
    .btn_step (btn_step),
    .btn_halt (btn_halt),
    .pc       (pc),
    .bp_addr  (bp_addr),
    .bp_valid (bp_valid),
    .cpu_en   (cpu_en),
    .state    (state),
    .cycle_cnt(cycle_cnt),
    .bp_hit   (bp_hit)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: presses predicted from how long each raw button has disagreed with its
  // accepted level; the sequencer is stepped from those predicted presses.
  int          m_st = 0;
  bit          m_flag = 1'b0;
  logic [31:0] m_cnt = 32'h0;
  bit          m_valid = 1'b0;
  bit          pc_auto = 1'b0;
  logic [31:0] pc_base = 32'h0;
  bit   [2:0]  m_raw1, m_raw2, m_lvl, m_press;
  int          m_run [3];

  function automatic bit m_en();
    if (m_st == 1) return !(BP_EN && bp_valid && pc == bp_addr);
    return (m_st == 2) || (m_st == 4);
  endfunction

  always @(posedge clk) begin : model
    bit [2:0] raw;
    bit en, h, s, r;
    raw = {btn_halt, btn_step, btn_run};
    if (rst) begin
      m_st = 0; m_flag = 1'b0; m_cnt = 32'h0;
      m_raw1 = '0; m_raw2 = '0; m_lvl = '0; m_press = '0;
      for (int i = 0; i < 3; i++) m_run[i] = 0;
      m_valid = 1'b1;
      pc <= pc_base;
    end else begin
      en = m_en();
      {h, s, r} = m_press;
      if (en) m_cnt = m_cnt + 32'd1;
      if (!pc_auto) pc <= pc_base;
      else if (en)  pc <= pc + 32'd4;
      if (h) m_st = 0;
      else case (m_st)
        0: if (s) m_st = 2; else if (r) m_st = 1;
        1: if (BP_EN && bp_valid && pc == bp_addr) m_st = 3;
        2: m_st = 0;
        3: if (s || r) begin m_flag = !s; m_st = 4; end
        4: m_st = m_flag ? 1 : 0;
        default: m_st = 0;
      endcase
      for (int i = 0; i < 3; i++) begin
        // The synchronized sample used at this edge is the raw value from two edges ago
        m_run[i] = (m_raw2[i] != m_lvl[i]) ? m_run[i] + 1 : 0;
        m_press[i] = 1'b0;
        if (m_run[i] == D) begin
          m_lvl[i]   = ~m_lvl[i];
          m_press[i] = m_lvl[i];
          m_run[i]   = 0;
        end
      end
      m_raw2 = m_raw1;
      m_raw1 = raw;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_state", {29'd0, state}, m_st);
      chk("model_cpu_en", {31'd0, cpu_en}, {31'd0, m_en()});
      chk("model_cycle_cnt", cycle_cnt, m_cnt);
      chk("model_bp_hit", {31'd0, bp_hit}, {31'd0, (m_st == 3)});
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    int ens, first, n;
    bit seen_a, seen_b;

    // Reset held two cycles with run pressed
    rst = 1'b1; btn_run = 1'b1; pc_base = 32'h0;
    @(posedge clk); @(negedge clk);
    chk("reset_state", {29'd0, state}, 32'd0);
    chk("reset_cpu_en", {31'd0, cpu_en}, 32'd0);
    chk("reset_cycle_cnt", cycle_cnt, 32'd0);
    @(posedge clk); @(negedge clk);
    chk("reset_state2", {29'd0, state}, 32'd0);
    chk("reset_cycle_cnt2", cycle_cnt, 32'd0);
    @(posedge clk); #2;
    rst = 1'b0; btn_run = 1'b0;
    cyc(4);

    // Single step: held step gives exactly one enabled cycle
    btn_step = 1'b1;
    ens = 0;
    repeat (20) begin @(negedge clk); ens += int'(cpu_en); end
    @(posedge clk); #2;
    btn_step = 1'b0;
    chk("step_en_cycles", ens, 32'd1);
    chk("step_cycle_cnt", cycle_cnt, 32'd1);
    chk("step_state", {29'd0, state}, 32'd0);
    cyc(8);

    // Bounce rejection then a clean hold of run
    btn_run = 1'b1; cyc(1); btn_run = 1'b0; cyc(1);
    btn_run = 1'b1; cyc(1); btn_run = 1'b0; cyc(1);
    btn_run = 1'b1;
    first = -1;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      if (first < 0 && state == 3'd1) first = j;
      if (j == 9) chk("run_cycle_cnt", cycle_cnt, 32'd3);
    end
    chk("run_first_cycle", first, 32'd7);
    @(posedge clk); #2;
    btn_run = 1'b0;
    cyc(8);

    // Counter wrap while running
    @(negedge clk); #1;
    force dut.cycle_cnt_reg = 32'hFFFF_FFFF;
    m_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.cycle_cnt_reg;
    @(negedge clk);
    chk("wrap_cycle_cnt", cycle_cnt, 32'h0);
    @(posedge clk); #2;

    // Halt and run together while running: halt wins
    btn_halt = 1'b1; btn_run = 1'b1;
    cyc(8);
    btn_halt = 1'b0; btn_run = 1'b0;
    cyc(8);
    @(negedge clk);
    chk("halt_run_state", {29'd0, state}, 32'd0);
    @(posedge clk); #2;

    // Step and run together while halted: step wins
    btn_step = 1'b1; btn_run = 1'b1;
    seen_a = 1'b0; seen_b = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (state == 3'd2) seen_a = 1'b1;
      if (state == 3'd1) seen_b = 1'b1;
    end
    @(posedge clk); #2;
    btn_step = 1'b0; btn_run = 1'b0;
    chk("step_run_saw_step", {31'd0, seen_a}, 32'd1);
    chk("step_run_saw_run", {31'd0, seen_b}, 32'd0);
    cyc(8);

`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
    // Breakpoint: run from 0x0040_0000 and stop before 0x0040_0010
    rst = 1'b1; pc_base = 32'h0040_0000;
    bp_addr = 32'h0040_0010; bp_valid = 1'b1;
    cyc(2);
    rst = 1'b0; pc_auto = 1'b1; btn_run = 1'b1;
    n = 0;
    while (state != 3'd3 && n < 40) begin @(negedge clk); n++; end
    chk("bp_reached", {31'd0, (state == 3'd3)}, 32'd1);
    chk("bp_cycle_cnt", cycle_cnt, 32'd4);
    chk("bp_hit", {31'd0, bp_hit}, 32'd1);
    chk("bp_cpu_en", {31'd0, cpu_en}, 32'd0);
    chk("bp_pc", pc, 32'h0040_0010);
    @(posedge clk); #2;
    btn_run = 1'b0;
    cyc(8);
    btn_step = 1'b1;
    seen_a = 1'b0; n = 0;
    while (!(seen_a && state == 3'd0) && n < 30) begin
      @(negedge clk);
      if (state == 3'd4) seen_a = 1'b1;
      n++;
    end
    chk("resume_seen", {31'd0, seen_a}, 32'd1);
    chk("resume_state", {29'd0, state}, 32'd0);
    chk("resume_cycle_cnt", cycle_cnt, 32'd5);
    @(posedge clk); #2;
    btn_step = 1'b0;
    cyc(8);
`else
    // Without breakpoints an armed match must not stop RUN
    bp_addr = 32'h0; bp_valid = 1'b1;
    btn_run = 1'b1; cyc(8); btn_run = 1'b0;
    cyc(3);
    @(negedge clk);
    chk("nobp_state", {29'd0, state}, 32'd1);
    chk("nobp_bp_hit", {31'd0, bp_hit}, 32'd0);
    chk("nobp_cpu_en", {31'd0, cpu_en}, 32'd1);
    @(posedge clk); #2;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
